// File: rtl/xmpl_dsp_seq_pkg.sv
// Shared types and width helpers for the xmpl_dsp_seq stage sequencer.
// Consumers: xmpl_dsp_seq (top) and xmpl_dsp_seq_sel (priority finder).
package xmpl_dsp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  // Width of a stage index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/xmpl_dsp_seq_sel.sv
// Combinational priority finder: lowest set mask bit at an index >= from_idx.
// from_idx is one bit wider than a stage index so "past the last stage" is representable.
module xmpl_dsp_seq_sel #(
  parameter int N_STAGES = 3,
  parameter int IW       = 2
) (
  input  logic [N_STAGES-1:0] mask,
  input  logic [IW:0]         from_idx,
  output logic                found,
  output logic [IW:0]         next_idx
);

  localparam int IW1 = IW + 1;

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (IW1'(i) >= from_idx)) begin
        found    = 1'b1;
        next_idx = IW1'(i);
      end
    end
  end

endmodule

// File: rtl/xmpl_dsp_seq.sv
// N-stage DSP pipeline sequencer: enables one masked stage at a time and waits for its done.
// Optional per-stage run timeout is built when XMPL_DSP_SEQ_TIMEOUT_EN is defined.
module xmpl_dsp_seq
  import xmpl_dsp_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int STATE_W     = 3,
  parameter int PASS_W      = 16,
  localparam int IW         = idx_w(N_STAGES)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                continuous_i,
  input  logic [N_STAGES-1:0] stage_mask_i,
  input  logic [N_STAGES-1:0] stage_status_i,
  output logic [N_STAGES-1:0] stage_en_o,
  output logic [IW-1:0]       cur_stage_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [PASS_W-1:0]   pass_cnt_o,
  output logic [STATE_W-1:0]  fsm_state_o
);

  localparam logic [2:0] ST_IDLE = 3'(S_IDLE);
  localparam logic [2:0] ST_SEL  = 3'(S_SEL);
  localparam logic [2:0] ST_RUN  = 3'(S_RUN);
  localparam logic [2:0] ST_GAP  = 3'(S_GAP);
  localparam logic [2:0] ST_DONE = 3'(S_DONE);
  localparam logic [2:0] ST_ERR  = 3'(S_ERR);
  localparam int         GW      = cnt_w(GAP_CYC);

  logic [2:0]          state_q;
  logic [IW:0]         idx_q;
  logic [N_STAGES-1:0] mask_q;
  logic [GW-1:0]       gap_q;
  logic [PASS_W-1:0]   pass_q;

  logic                restart;
  logic [N_STAGES-1:0] sel_mask;
  logic [IW:0]         sel_from;
  logic                sel_found;
  logic [IW:0]         sel_idx;
  logic                status_hit;
  logic                gap_last;
  logic                tmo_hit;

  // A continuous restart searches the freshly sampled mask from stage 0 while still in DONE,
  // so the first stage of the next pass is enabled the cycle after done_o.
  assign restart  = (state_q == ST_DONE) && continuous_i;
  assign sel_mask = restart ? stage_mask_i : mask_q;
  assign sel_from = restart ? '0 : idx_q;

  xmpl_dsp_seq_sel #(
    .N_STAGES(N_STAGES),
    .IW      (IW)
  ) u_sel (
    .mask    (sel_mask),
    .from_idx(sel_from),
    .found   (sel_found),
    .next_idx(sel_idx)
  );

  assign status_hit = (state_q == ST_RUN) && stage_status_i[idx_q[IW-1:0]];
  assign gap_last   = (int'(gap_q) >= GAP_CYC - 1);

`ifdef XMPL_DSP_SEQ_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYC);
  logic [TW-1:0] tmo_q;

  // Held at zero outside RUN, so it restarts from zero on every RUN entry.
  always_ff @(posedge clk_i) begin
    if (reset_i || (state_q != ST_RUN)) tmo_q <= '0;
    else                                tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == ST_RUN) && (int'(tmo_q) >= TIMEOUT_CYC - 1);
  assign err_o   = (state_q == ST_ERR);
`else
  // Feature off: the timeout value is only referenced to keep the parameter list uniform.
  assign tmo_hit = (TIMEOUT_CYC < 0) && 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      gap_q   <= '0;
      pass_q  <= '0;
    end else if (abort_i && (state_q != ST_IDLE)) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start_i) begin
            state_q <= ST_SEL;
            mask_q  <= stage_mask_i;
            idx_q   <= '0;
          end
        end
        ST_SEL: begin
          if (sel_found) begin
            state_q <= ST_RUN;
            idx_q   <= sel_idx;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (status_hit) begin
            idx_q   <= idx_q + 1'b1;
            gap_q   <= '0;
            state_q <= (GAP_CYC > 0) ? ST_GAP : ST_SEL;
          end else if (tmo_hit) begin
            state_q <= ST_ERR;
          end
        end
        ST_GAP: begin
          if (gap_last) state_q <= ST_SEL;
          else          gap_q   <= gap_q + 1'b1;
        end
        ST_DONE: begin
          pass_q <= pass_q + 1'b1;
          if (continuous_i) begin
            mask_q <= stage_mask_i;
            if (sel_found) begin
              state_q <= ST_RUN;
              idx_q   <= sel_idx;
            end else begin
              state_q <= ST_SEL;
              idx_q   <= '0;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stage_en_o = '0;
    if (state_q == ST_RUN) stage_en_o[idx_q[IW-1:0]] = 1'b1;
  end

  assign cur_stage_o = idx_q[IW-1:0];
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign done_o      = (state_q == ST_DONE);
  assign pass_cnt_o  = pass_q;
  assign fsm_state_o = STATE_W'(state_q);

endmodule
